exe_muldiv_ctrl: RTL and testbench
==================================

Name: exe_muldiv_ctrl

Overview:
Iterative multiply/divide sequencer for the RV32M ops, attached beside the execute-stage ALU. It accepts one operation at a time from execute and owns a shared 32-iteration shift/add-subtract datapath. While the operation runs, it raises a stall request toward the pipeline, then returns the result with its destination tag over a valid/ready handshake. A pipeline flush aborts the operation in flight.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  execute presents a M-extension op
in_ready  out  1  controller can accept (state IDLE)
in_op  in  3  0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
in_op1  in  XLEN  rs1 value
in_op2  in  XLEN  rs2 value
in_rd  in  5  destination register tag
flush  in  1  abort current op, return to IDLE
out_valid  out  1  result available (state DONE)
out_ready  in  1  memory-stage side accepts result
out_result  out  XLEN  result
out_rd  out  5  destination tag echoed from accept
stall_req  out  1  high whenever state is not IDLE and not (DONE and out_ready)

Behaviour:
- Reset (rst=1, async): state IDLE, counter 0, all datapath regs 0; in_ready=1, out_valid=0, out_result=0, out_rd=0, stall_req=0.
- States: IDLE, CALC, SPECIAL, FIX, DONE.
- IDLE: accept on edge with in_valid&in_ready; latch op, operands, rd, operand sign flags. Go to SPECIAL if divide op with op2==0 or signed overflow (DIV/REM, op1=0x80000000, op2=0xFFFFFFFF); else CALC with counter=0.
- CALC: one iteration per cycle; counter increments; on edge with counter==31 go to FIX (32 CALC cycles exactly).
- MUL path: unsigned shift-add on magnitudes into 64-bit product register. Signedness per op: MULH both signed, MULHSU op1 signed only, MULHU/MUL unsigned magnitudes (MUL low word sign-agnostic).
- DIV path: restoring division on magnitudes, 32-bit quotient and 33-bit partial remainder.
- FIX (1 cycle): apply sign correction. Product negated if sign flags differ. Quotient negated if dividend and divisor signs differ. Remainder takes dividend sign. Then select: low word (MUL), high word (MULH*), quotient (DIV*), remainder (REM*). Go to DONE.
- SPECIAL (1 cycle):
  - Divide by zero: quotient 0xFFFFFFFF, remainder = op1 (both signed and unsigned).
  - Overflow: quotient 0x80000000, remainder 0.
  - Then go to DONE.
- Latency: normal op has out_valid high 34 cycles after the accepting edge; special case has it high 2 cycles after.
- DONE: out_valid=1, out_result/out_rd stable until out_ready sampled high. Transfer on edge with out_valid&out_ready, then go to IDLE. No back-to-back accept in the same edge; in_ready only in IDLE.
- flush has priority over every transition. Any state goes to IDLE next edge, out_valid drops, result discarded. A flush in IDLE coincident with in_valid means no accept.
- in_valid while busy: ignored (in_ready=0); the upstream holds the op via stall_req.
- Reset asserted mid-operation: immediate return to reset values; no output produced.

Decomposition:
- Shared package (muldiv_pkg): op encodings (3-bit localparams), state encodings, XLEN default, constants INT_MIN=0x80000000 and ALL_ONES.
- One sub-module, muldiv_iter_core: combinational single-iteration step (shift-add or restore-subtract) plus final negate/select. The FSM, counter, handshake and latches stay in exe_muldiv_ctrl.

Test Plan:
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD), rd=5 -> out_valid 34 cycles after accept, result 0xFFFFFFEB, out_rd=5; stall_req high throughout.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each 2 cycles after accept. DIV 0x80000000/-1 -> 0x80000000 and REM same operands -> 0.
- flush at cycle 10 of CALC -> IDLE next edge, out_valid never rises, in_ready=1. Next op DIVU 9/3 -> 3.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid, result, rd stable and stall_req high; second in_valid ignored until handshake completes. Assert rst mid-CALC -> all outputs at reset values immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the RV32M iterative multiply/divide sequencer.
package muldiv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 5;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_SPECIAL,
        ST_FIX,
        ST_DONE
    } state_t;

    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op1_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op2_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One shift-add / restoring-subtract step on magnitudes, plus the final sign fix and result select.
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] b,
    input  logic            neg_a,
    input  logic            neg_b,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next,
    output logic [XLEN-1:0] result
);

    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hi_next = '0;
        lo_next = '0;
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, b};
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        if (is_div_op(op)) begin
            // Partial remainder stays below the divisor, so diff's top bit is exactly the borrow.
            if (!diff[XLEN]) begin
                hi_next = diff[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = shifted[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

    always_comb begin
        result  = '0;
        product = {hi, lo};
        if (neg_a ^ neg_b) begin
            product = -product;
        end
        quo = (neg_a ^ neg_b) ? -lo : lo;
        rem = neg_a ? -hi : hi;
        case (op)
            OP_MUL:                       result = product[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = product[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = quo;
            default:                      result = rem;
        endcase
    end

endmodule

// File: rtl/exe_muldiv_ctrl.sv
// Execute-stage RV32M sequencer: accepts one op, runs 32 iterations, returns result with its rd tag.
module exe_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_op1,
    input  logic [XLEN-1:0] in_op2,
    input  logic [4:0]      in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            stall_req
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;

    logic [XLEN-1:0]   hi_step, lo_step, fix_result;
    logic [XLEN-1:0]   mag1, mag2;
    logic              in_s1, in_s2, in_special, accept;

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .op      (op_q),
        .hi      (hi_q),
        .lo      (lo_q),
        .b       (b_q),
        .neg_a   (neg_a_q),
        .neg_b   (neg_b_q),
        .hi_next (hi_step),
        .lo_next (lo_step),
        .result  (fix_result)
    );

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_result = res_q;
    assign out_rd     = rd_q;
    assign stall_req  = (state_q != ST_IDLE) && !(out_valid && out_ready);

    assign accept     = in_valid && in_ready && !flush;
    assign in_s1      = op1_signed(in_op) && in_op1[XLEN-1];
    assign in_s2      = op2_signed(in_op) && in_op2[XLEN-1];
    assign mag1       = in_s1 ? -in_op1 : in_op1;
    assign mag2       = in_s2 ? -in_op2 : in_op2;
    assign in_special = is_div_op(in_op) &&
                        ((in_op2 == '0) ||
                         (((in_op == OP_DIV) || (in_op == OP_REM)) &&
                          (in_op1 == INT_MIN) && (in_op2 == ALL_ONES)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        res_d   = res_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = in_op;
                    rd_d    = in_rd;
                    neg_a_d = in_s1;
                    neg_b_d = in_s2;
                    hi_d    = '0;
                    cnt_d   = '0;
                    if (in_special) begin
                        // Raw operands kept so SPECIAL can return op1 as the remainder.
                        lo_d    = in_op1;
                        b_d     = in_op2;
                        state_d = ST_SPECIAL;
                    end else if (is_div_op(in_op)) begin
                        lo_d    = mag1;
                        b_d     = mag2;
                        state_d = ST_CALC;
                    end else begin
                        lo_d    = mag2;
                        b_d     = mag1;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                hi_d  = hi_step;
                lo_d  = lo_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_SPECIAL: begin
                // op[1] separates REM/REMU from DIV/DIVU.
                if (b_q == '0) begin
                    res_d = op_q[1] ? lo_q : ALL_ONES;
                end else begin
                    res_d = op_q[1] ? '0 : INT_MIN;
                end
                state_d = ST_DONE;
            end
            ST_FIX: begin
                res_d   = fix_result;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the datapath registers are reset too, so out_result/out_rd read zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            res_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            res_q   <= res_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
        end
    end

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// Self-checking bench for exe_muldiv_ctrl: arithmetic reference model plus directed literal vectors.
module tb_exe_muldiv_ctrl;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready, stall_req;
    logic [2:0]  in_op;
    logic [31:0] in_op1, in_op2, out_result;
    logic [4:0]  in_rd, out_rd;

    int n_cmp = 0;
    int n_bad = 0;

    exe_muldiv_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_op1     (in_op1),
        .in_op2     (in_op2),
        .in_rd      (in_rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .stall_req  (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results straight from the RV32M definitions using host arithmetic.
    function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        logic [63:0] pu;
        longint      ps;
        int          sa, sb;
        logic        ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            MUL:    begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
            MULH:   begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
            MULHSU: begin ps = longint'(sa) * longint'({32'b0, b}); return ps[63:32]; end
            MULHU:  begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        logic special;
        special = op[2] && ((b == 0) ||
                  (((op == DIV) || (op == REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
        return special ? 2 : 34;
    endfunction

    // Transaction-level model: busy flag, age in cycles since accept, expected result.
    bit          m_busy = 1'b0;
    int          m_age = 0;
    int          m_lat = 0;
    logic [31:0] m_res = '0;
    logic [4:0]  m_rd = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
        end else if (flush) begin
            m_busy <= 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_age  <= 1;
                m_lat  <= model_latency(in_op, in_op1, in_op2);
                m_res  <= model_result(in_op, in_op1, in_op2);
                m_rd   <= in_rd;
            end
        end else if ((m_age >= m_lat) && out_ready) begin
            m_busy <= 1'b0;
        end else begin
            m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin : compare
        bit ev;
        ev = m_busy && (m_age >= m_lat);
        check("in_ready", 32'(in_ready), 32'(!m_busy));
        check("out_valid", 32'(out_valid), 32'(ev));
        check("stall_req", 32'(stall_req), 32'(m_busy && !(ev && out_ready)));
        if (ev) begin
            check("out_result", out_result, m_res);
            check("out_rd", 32'(out_rd), 32'(m_rd));
        end
    end

    task automatic wait_valid(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 60);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        in_op    = op;
        in_op1   = a;
        in_op2   = b;
        in_rd    = rd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(tag, exp_lat);
        check({tag, " result"}, out_result, exp);
        check({tag, " rd"}, 32'(out_rd), 32'(rd));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " out_result"}, out_result, 32'd0);
        check({tag, " out_rd"}, 32'(out_rd), 32'd0);
        check({tag, " stall_req"}, 32'(stall_req), 32'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit saw;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_op1    = '0;
        in_op2    = '0;
        in_rd     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Pin the reference model to hand-computed values.
        check("model MUL", model_result(MUL, 32'h7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("model MULHSU", model_result(MULHSU, 32'hFFFF_FFFF, 32'h2), 32'hFFFF_FFFF);
        check("model REM", model_result(REM, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFF);
        check("model DIV ovf", model_result(DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        #1 rst = 1'b0;

        run_op("MUL", MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 34);
        run_op("MULH", MULH, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 34);
        run_op("MULHU", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 34);
        run_op("MULHSU", MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 32'hFFFF_FFFF, 34);
        run_op("MULH -1x1", MULH, 32'hFFFF_FFFF, 32'h0000_0001, 5'd8, 32'hFFFF_FFFF, 34);
        run_op("MULHU -1x1", MULHU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd9, 32'h0000_0000, 34);
        run_op("DIV", DIV, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4, 32'hFFFF_FFFD, 34);
        run_op("REM", REM, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6, 32'hFFFF_FFFF, 34);
        run_op("DIV neg/neg", DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd10, 32'h0000_0003, 34);
        run_op("DIVU", DIVU, 32'd100, 32'd7, 5'd11, 32'd14, 34);
        run_op("REMU", REMU, 32'd100, 32'd7, 5'd12, 32'd2, 34);
        run_op("DIV by 0", DIV, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 2);
        run_op("REM by 0", REM, 32'd5, 32'd0, 5'd14, 32'd5, 2);
        run_op("DIVU by 0", DIVU, 32'd5, 32'd0, 5'd15, 32'hFFFF_FFFF, 2);
        run_op("REMU by 0", REMU, 32'd5, 32'd0, 5'd16, 32'd5, 2);
        run_op("DIV ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 2);
        run_op("REM ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0000_0000, 2);
        run_op("DIVU no ovf", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h0000_0000, 34);
        run_op("REMU no ovf", REMU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 34);

        // Flush during the tenth CALC cycle.
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        in_op    = MUL;
        in_op1   = 32'd123;
        in_op2   = 32'd456;
        in_rd    = 5'd21;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush in_ready", 32'(in_ready), 32'd1);
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush stall_req", 32'(stall_req), 32'd0);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        check("flush no result", 32'(saw), 32'd0);

        // Flush in IDLE coincident with in_valid must not accept.
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        flush    = 1'b1;
        in_op    = DIVU;
        in_op1   = 32'd50;
        in_op2   = 32'd5;
        in_rd    = 5'd22;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush idle no accept", 32'(in_ready), 32'd1);
        run_op("DIVU after flush", DIVU, 32'd9, 32'd3, 5'd23, 32'd3, 34);

        // Back-pressure in DONE with a second op waiting upstream.
        @(negedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = MUL;
        in_op1    = 32'h0000_1234;
        in_op2    = 32'h0000_0010;
        in_rd     = 5'd7;
        @(posedge clk);
        #1;
        in_op  = DIVU;
        in_op1 = 32'd100;
        in_op2 = 32'd7;
        in_rd  = 5'd9;
        wait_valid("hold MUL", 34);
        for (int i = 0; i < 5; i++) begin
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold result", out_result, 32'h0001_2340);
            check("hold rd", 32'(out_rd), 32'd7);
            check("hold stall_req", 32'(stall_req), 32'd1);
            check("hold in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("handshake out_valid", 32'(out_valid), 32'd0);
        check("handshake in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid("queued DIVU", 34);
        check("queued DIVU result", out_result, 32'd14);
        check("queued DIVU rd", 32'(out_rd), 32'd9);

        // Reset asserted mid-CALC.
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        in_op    = MULHU;
        in_op1   = 32'hDEAD_BEEF;
        in_op2   = 32'h1234_5678;
        in_rd    = 5'd30;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("mid rst");
        @(negedge clk);
        #1 rst = 1'b0;
        run_op("REMU after rst", REMU, 32'd100, 32'd7, 5'd31, 32'd2, 34);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
